// File: rtl/mips_pkg.sv
// Shared MIPS EX-stage definitions: ALUOp codes, funct fields, ALU control codes
// and the multiply/divide sequencer state encoding.
package mips_pkg;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_SLT   = 2'b11
    } alu_op_e;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_XOR   = 4'b0011;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SLT   = 4'b0111;
    localparam logic [3:0] ALU_JR    = 4'b1000;
    localparam logic [3:0] ALU_SLTU  = 4'b1001;
    localparam logic [3:0] ALU_MDNOP = 4'b1010;
    localparam logic [3:0] ALU_NOR   = 4'b1100;
    localparam logic [3:0] ALU_SRA   = 4'b1101;
    localparam logic [3:0] ALU_SRL   = 4'b1110;
    localparam logic [3:0] ALU_SLL   = 4'b1111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2,
        MD_DONE = 2'd3
    } md_state_e;

    function automatic logic is_md_op(input logic [5:0] f);
        return (f == FN_MULT) || (f == FN_MULTU) || (f == FN_DIV) || (f == FN_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [5:0] f);
        return (f == FN_DIV) || (f == FN_DIVU);
    endfunction

    function automatic logic is_signed_md(input logic [5:0] f);
        return (f == FN_MULT) || (f == FN_DIV);
    endfunction

endpackage

// File: rtl/alu_ctrl_muldiv_if.sv
// EX-stage bus between the main control FSM (master) and the ALU control /
// multiply-divide block (slave).
interface alu_ctrl_muldiv_if #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
);
    logic [1:0]        alu_op;
    logic [5:0]        funct;
    logic              issue_i;
    logic [WIDTH-1:0]  rs_val;
    logic [WIDTH-1:0]  rt_val;
    logic [CTRL_W-1:0] alu_ctrl_o;
    logic              jr_o;
    logic              md_sel_o;
    logic [WIDTH-1:0]  md_rdata_o;
    logic              stall_o;
    logic              md_busy_o;
    logic              md_done_o;
    logic              div0_o;

    modport master (
        output alu_op, funct, issue_i, rs_val, rt_val,
        input  alu_ctrl_o, jr_o, md_sel_o, md_rdata_o, stall_o, md_busy_o, md_done_o, div0_o
    );

    modport slave (
        input  alu_op, funct, issue_i, rs_val, rt_val,
        output alu_ctrl_o, jr_o, md_sel_o, md_rdata_o, stall_o, md_busy_o, md_done_o, div0_o
    );

endinterface

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide sequencer: radix-2 shift-add multiply, restoring divide,
// one bit per cycle, with signed magnitude pre-processing and final sign fix-up into HI/LO.
module muldiv_iter
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_is_div,
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_rs,
    input  logic [WIDTH-1:0] i_rt,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_div0
);

    localparam int CW = $clog2(WIDTH + 1);

    md_state_e          r_state;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_acc;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_zero_div;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;
    logic               r_div0;

    logic [WIDTH-1:0]   w_abs_rs;
    logic [WIDTH-1:0]   w_abs_rt;
    logic               w_zero_div;
    logic [WIDTH-1:0]   w_acc_lo;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH-1:0]   w_rem_diff;
    logic               w_q_bit;
    logic [2*WIDTH-1:0] w_div_next;
    logic [WIDTH-1:0]   w_quot_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_abs_rs   = (i_signed && i_rs[WIDTH-1]) ? -i_rs : i_rs;
    assign w_abs_rt   = (i_signed && i_rt[WIDTH-1]) ? -i_rt : i_rt;
    assign w_zero_div = i_is_div && (i_rt == '0);
    // A zero divisor keeps the raw dividend so it can be returned in HI unchanged.
    assign w_acc_lo   = !i_is_div ? w_abs_rt : (w_zero_div ? i_rs : w_abs_rs);

    // Multiply: acc = {partial product, remaining multiplier bits}.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_b};
    assign w_mul_next = r_acc[0] ? {w_mul_sum, r_acc[WIDTH-1:1]}
                                 : {1'b0, r_acc[2*WIDTH-1:1]};
    assign w_prod_fix = r_neg_q ? -w_mul_next : w_mul_next;

    // Divide: acc = {partial remainder, dividend bits shifting into quotient}.
    assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_q_bit    = (w_rem_sh >= {1'b0, r_b});
    assign w_rem_diff = w_rem_sh[WIDTH-1:0] - r_b;
    assign w_div_next = {(w_q_bit ? w_rem_diff : w_rem_sh[WIDTH-1:0]), r_acc[WIDTH-2:0], w_q_bit};
    assign w_quot_fix = r_neg_q ? -w_div_next[WIDTH-1:0] : w_div_next[WIDTH-1:0];
    assign w_rem_fix  = r_neg_r ? -w_div_next[2*WIDTH-1:WIDTH] : w_div_next[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= MD_IDLE;
            r_cnt      <= '0;
            r_b        <= '0;
            r_acc      <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_zero_div <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div0     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                MD_IDLE, MD_DONE: begin
                    r_state <= MD_IDLE;
                    r_busy  <= 1'b0;
                    if (i_start) begin
                        r_state    <= i_is_div ? MD_DIV : MD_MUL;
                        r_busy     <= 1'b1;
                        r_div0     <= 1'b0;
                        r_cnt      <= CW'(WIDTH);
                        r_zero_div <= w_zero_div;
                        r_b        <= i_is_div ? w_abs_rt : w_abs_rs;
                        r_acc      <= {{WIDTH{1'b0}}, w_acc_lo};
                        r_neg_q    <= i_signed && (i_rs[WIDTH-1] ^ i_rt[WIDTH-1]);
                        r_neg_r    <= i_signed && i_rs[WIDTH-1];
                    end
                end
                MD_MUL: begin
                    r_acc <= w_mul_next;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        {r_hi, r_lo} <= w_prod_fix;
                        r_state      <= MD_DONE;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                    end
                end
                MD_DIV: begin
                    // Divide by zero spends this single DIV cycle without iterating.
                    if (r_zero_div) begin
                        r_hi    <= r_acc[WIDTH-1:0];
                        r_lo    <= '1;
                        r_div0  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= MD_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_acc <= w_div_next;
                        r_cnt <= r_cnt - CW'(1);
                        if (r_cnt == CW'(1)) begin
                            r_hi    <= w_rem_fix;
                            r_lo    <= w_quot_fix;
                            r_state <= MD_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= MD_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_hi   = r_hi;
    assign o_lo   = r_lo;
    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_div0 = r_div0;

endmodule

// File: rtl/alu_ctrl_muldiv.sv
// EX-stage ALU control: ALUOp/funct decode, multiply/divide issue and stall,
// and the HI/LO read path for mfhi/mflo.
module alu_ctrl_muldiv
    import mips_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    alu_ctrl_muldiv_if.slave bus
);

    logic [3:0]       w_ctrl;
    logic             w_jr;
    logic             w_rtype;
    logic             w_is_mf;
    logic             w_md_start;
    logic             w_is_div;
    logic             w_signed;
    logic [WIDTH-1:0] w_rdata;
    logic [WIDTH-1:0] w_hi;
    logic [WIDTH-1:0] w_lo;
    logic             w_busy;
    logic             w_done;
    logic             w_div0;

    always_comb begin
        w_ctrl = ALU_AND;
        w_jr   = 1'b0;
        case (alu_op_e'(bus.alu_op))
            ALUOP_ADD: w_ctrl = ALU_ADD;
            ALUOP_SUB: w_ctrl = ALU_SUB;
            ALUOP_SLT: w_ctrl = ALU_SLT;
            ALUOP_RTYPE: begin
                case (bus.funct)
                    FN_ADD, FN_ADDU:  w_ctrl = ALU_ADD;
                    FN_SUB, FN_SUBU:  w_ctrl = ALU_SUB;
                    FN_AND:           w_ctrl = ALU_AND;
                    FN_OR:            w_ctrl = ALU_OR;
                    FN_XOR:           w_ctrl = ALU_XOR;
                    FN_NOR:           w_ctrl = ALU_NOR;
                    FN_SLT:           w_ctrl = ALU_SLT;
                    FN_SLTU:          w_ctrl = ALU_SLTU;
                    FN_SLL:           w_ctrl = ALU_SLL;
                    FN_SRL:           w_ctrl = ALU_SRL;
                    FN_SRA:           w_ctrl = ALU_SRA;
                    FN_JR: begin
                        w_ctrl = ALU_JR;
                        w_jr   = 1'b1;
                    end
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU,
                    FN_MFHI, FN_MFLO: w_ctrl = ALU_MDNOP;
                    default:          w_ctrl = ALU_AND;
                endcase
            end
            default: w_ctrl = ALU_AND;
        endcase
    end

    assign w_rtype    = (bus.alu_op == ALUOP_RTYPE);
    assign w_is_mf    = w_rtype && ((bus.funct == FN_MFHI) || (bus.funct == FN_MFLO));
    assign w_is_div   = is_div_op(bus.funct);
    assign w_signed   = is_signed_md(bus.funct);
    // Issues while the sequencer is iterating are dropped; stall_o keeps the control FSM from trying.
    assign w_md_start = bus.issue_i && w_rtype && is_md_op(bus.funct) && !w_busy;

    muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_muldiv_iter (
        .clk      (clk),
        .rst_n    (reset_n),
        .i_start  (w_md_start),
        .i_is_div (w_is_div),
        .i_signed (w_signed),
        .i_rs     (bus.rs_val),
        .i_rt     (bus.rt_val),
        .o_hi     (w_hi),
        .o_lo     (w_lo),
        .o_busy   (w_busy),
        .o_done   (w_done),
        .o_div0   (w_div0)
    );

    // HI/LO are written on the edge entering DONE, so a stalled mfhi/mflo sees the new value there.
    always_comb begin
        w_rdata = '0;
        if (w_rtype && (bus.funct == FN_MFHI)) begin
            w_rdata = w_hi;
        end else if (w_rtype && (bus.funct == FN_MFLO)) begin
            w_rdata = w_lo;
        end
    end

    assign bus.alu_ctrl_o = CTRL_W'(w_ctrl);
    assign bus.jr_o       = w_jr;
    assign bus.md_sel_o   = w_is_mf;
    assign bus.md_rdata_o = w_rdata;
    assign bus.stall_o    = w_busy || w_md_start;
    assign bus.md_busy_o  = w_busy;
    assign bus.md_done_o  = w_done;
    assign bus.div0_o     = w_div0;

endmodule
